// File: rtl/uart_cmd_ctrl.sv
// Command sequencer between uart_core and the MiniGPU register bus: parses
// SYNC/OPC/ADDR[/DATA] frames, issues register strobes, returns one byte per command.
module uart_cmd_ctrl #(
  parameter int          BYTE_TIMEOUT = 50_000,
  parameter int          RD_TIMEOUT   = 256,
  parameter logic [7:0]  ACK_BYTE     = 8'h4B,
  parameter logic [7:0]  ERR_BYTE     = 8'h45
) (
  input  logic       CLK,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  input  logic       reg_rvalid,
  output logic       busy,
  output logic [7:0] drop_cnt,
  output logic [2:0] dbg_state
);

  // Handshakes: rx_valid is a one-cycle strobe with no back-pressure (bytes
  // arriving while not parsing are dropped). tx_valid/tx_ready: the byte moves
  // in a cycle where both are 1; until then tx_valid and tx_data hold steady.
  // reg_we/reg_re are single-cycle strobes; reg_rvalid qualifies reg_rdata.

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] OPC_WRITE = 8'h01;
  localparam logic [7:0] OPC_READ  = 8'h02;

  localparam int BT_W = (BYTE_TIMEOUT > 2) ? $clog2(BYTE_TIMEOUT) : 1;
  localparam int RT_W = (RD_TIMEOUT > 2) ? $clog2(RD_TIMEOUT) : 1;
  localparam logic [BT_W-1:0] BT_LAST = BT_W'(BYTE_TIMEOUT - 1);
  localparam logic [RT_W-1:0] RT_LAST = RT_W'(RD_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_OPC    = 3'd1,
    S_ADDR   = 3'd2,
    S_DATA   = 3'd3,
    S_WR     = 3'd4,
    S_RD     = 3'd5,
    S_WAITRD = 3'd6,
    S_RESP   = 3'd7
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            rx_v_q;
  logic [7:0]      rx_d_q;
  logic [7:0]      opc;
  logic [BT_W-1:0] byte_tmr;
  logic [RT_W-1:0] rd_tmr;
  logic [7:0]      resp_byte;

  logic in_frame;
  logic byte_abort;
  logic rd_expire;
  logic bad_opc;
  logic drop_byte;

  // Received bytes are registered once; the FSM acts on the registered copy,
  // which puts reg_we two cycles after the strobe of the DATA byte.
  assign in_frame   = (state == S_OPC) || (state == S_ADDR) || (state == S_DATA);
  assign byte_abort = in_frame && !rx_v_q && (byte_tmr == BT_LAST);
  assign rd_expire  = (state == S_WAITRD) && !reg_rvalid && (rd_tmr == RT_LAST);
  assign bad_opc    = (opc != OPC_WRITE) && (opc != OPC_READ);
  assign drop_byte  = rx_v_q &&
                      (((state == S_IDLE) && (rx_d_q != SYNC_BYTE)) ||
                       (state == S_WR) || (state == S_RD) ||
                       (state == S_WAITRD) || (state == S_RESP));

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (rx_v_q && (rx_d_q == SYNC_BYTE)) state_nxt = S_OPC;
      end
      S_OPC: begin
        if (rx_v_q)          state_nxt = S_ADDR;
        else if (byte_abort) state_nxt = S_IDLE;
      end
      S_ADDR: begin
        if (rx_v_q) begin
          if (opc == OPC_WRITE)     state_nxt = S_DATA;
          else if (opc == OPC_READ) state_nxt = S_RD;
          else                      state_nxt = S_RESP;
        end else if (byte_abort) begin
          state_nxt = S_IDLE;
        end
      end
      S_DATA: begin
        if (rx_v_q)          state_nxt = S_WR;
        else if (byte_abort) state_nxt = S_IDLE;
      end
      S_WR:     state_nxt = S_RESP;
      S_RD:     state_nxt = S_WAITRD;
      S_WAITRD: begin
        if (reg_rvalid || rd_expire) state_nxt = S_RESP;
      end
      S_RESP: begin
        if (tx_ready) state_nxt = S_IDLE;
      end
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    reg_we    = 1'b0;
    reg_re    = 1'b0;
    tx_valid  = 1'b0;
    busy      = 1'b1;
    tx_data   = resp_byte;
    dbg_state = state;
    case (state)
      S_IDLE: busy     = 1'b0;
      S_WR:   reg_we   = 1'b1;
      S_RD:   reg_re   = 1'b1;
      S_RESP: tx_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath: input register, field latches, timers, response byte, drop counter.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      rx_v_q    <= 1'b0;
      rx_d_q    <= 8'h00;
      opc       <= 8'h00;
      reg_addr  <= 8'h00;
      reg_wdata <= 8'h00;
      byte_tmr  <= '0;
      rd_tmr    <= '0;
      resp_byte <= 8'h00;
      drop_cnt  <= 8'h00;
    end else begin
      rx_v_q <= rx_valid;
      rx_d_q <= rx_data;

      if (rx_v_q || !in_frame) byte_tmr <= '0;
      else                     byte_tmr <= byte_tmr + 1'b1;

      // Cleared everywhere outside WAITRD, so it starts at 0 after the reg_re cycle.
      if (state == S_WAITRD) rd_tmr <= rd_tmr + 1'b1;
      else                   rd_tmr <= '0;

      if (rx_v_q) begin
        if (state == S_OPC)  opc       <= rx_d_q;
        if (state == S_ADDR) reg_addr  <= rx_d_q;
        if (state == S_DATA) reg_wdata <= rx_d_q;
      end

      case (state)
        S_ADDR: begin
          if (rx_v_q && bad_opc) resp_byte <= ERR_BYTE;
        end
        S_WR: resp_byte <= ACK_BYTE;
        S_WAITRD: begin
          if (reg_rvalid)     resp_byte <= reg_rdata;
          else if (rd_expire) resp_byte <= ERR_BYTE;
        end
        default: ;
      endcase

      if ((drop_byte || byte_abort) && (drop_cnt != 8'hFF)) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

endmodule
